// File: rtl/sync_ram_fifo_pkg.sv
// Shared types for the sync_ram_fifo controller: RAM-port arbitration decision
// and the width rule for the occupancy counter.
package sync_ram_fifo_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WRITE,
        ARB_FETCH
    } arb_e;

    // Occupancy spans 0..DEPTH+1, which needs one bit more than the address.
    function automatic int level_width(input int awidth);
        return awidth + 1;
    endfunction

endpackage

// File: rtl/sync_ram_fifo_out_stage.sv
// Output stage of sync_ram_fifo_ctrl: tracks the word in flight from the RAM,
// parks it in a one-word hold register when not consumed, and muxes the head.
module sync_ram_fifo_out_stage
    import sync_ram_fifo_pkg::*;
#(
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_fetch,
    input  logic              i_out_ready,
    input  logic [DWIDTH-1:0] i_ram_q,
    output logic              o_out_valid,
    output logic [DWIDTH-1:0] o_out_data
);

    logic              r_inflight;
    logic              r_hold_valid;
    logic [DWIDTH-1:0] r_hold_data;
    logic              w_pop;

    // The RAM word is only valid on ram_q the cycle after its fetch, so it is
    // bypassed straight out then and captured only if nobody takes it.
    assign o_out_valid = r_inflight || r_hold_valid;
    assign o_out_data  = r_inflight ? i_ram_q : r_hold_data;
    assign w_pop       = o_out_valid && i_out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight   <= 1'b0;
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
        end else begin
            r_inflight <= i_fetch;
            if (r_inflight && !w_pop) begin
                r_hold_valid <= 1'b1;
                r_hold_data  <= i_ram_q;
            end else if (w_pop) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sync_ram_fifo_ctrl.sv
// Ready/valid FWFT FIFO controller driving one external single-port SYNC_RAM.
// Optional registered almost_full: define SYNC_RAM_FIFO_AFULL_EN.
module sync_ram_fifo_ctrl
    import sync_ram_fifo_pkg::*;
#(
    parameter int DWIDTH       = 8,
    parameter int AWIDTH       = 8,
    parameter int AFULL_THRESH = (1 << AWIDTH) - 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_data,
    input  logic              out_ready,
    output logic [AWIDTH:0]   level,
    output logic              almost_full,
    output logic [AWIDTH-1:0] ram_addr,
    output logic              ram_we,
    output logic              ram_en,
    output logic [DWIDTH-1:0] ram_d,
    input  logic [DWIDTH-1:0] ram_q
);

    localparam int             DEPTH    = 1 << AWIDTH;
    localparam int             LW       = level_width(AWIDTH);
    localparam logic [AWIDTH:0] FULL_CNT = (AWIDTH + 1)'(DEPTH);

    logic [AWIDTH-1:0] r_wr_ptr;
    logic [AWIDTH-1:0] r_rd_ptr;
    logic [AWIDTH:0]   r_mem_cnt;
    logic [LW-1:0]     r_level;
    logic [LW-1:0]     w_level_nxt;
    logic              w_fetch;
    logic              w_push;
    logic              w_pop;
    arb_e              w_arb;

    // Fetch whenever the output stage will have room after this edge; it owns
    // the port that cycle, so writes back off.
    assign w_fetch  = (r_mem_cnt != '0) && (!out_valid || out_ready);
    assign in_ready = rst_n && (r_mem_cnt != FULL_CNT) && !w_fetch;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = out_valid && out_ready;

    // NOTE: every signal driven from always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_arb = ARB_IDLE;
        if (w_fetch) begin
            w_arb = ARB_FETCH;
        end else if (w_push) begin
            w_arb = ARB_WRITE;
        end
    end

    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_d    = '0;
        case (w_arb)
            ARB_FETCH: begin
                ram_en   = 1'b1;
                ram_addr = r_rd_ptr;
            end
            ARB_WRITE: begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = r_wr_ptr;
                ram_d    = in_data;
            end
            default: ;
        endcase
    end

    // Pointers wrap naturally; full/empty come from r_mem_cnt alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_mem_cnt <= '0;
        end else begin
            case (w_arb)
                ARB_FETCH: begin
                    r_rd_ptr  <= r_rd_ptr + 1'b1;
                    r_mem_cnt <= r_mem_cnt - 1'b1;
                end
                ARB_WRITE: begin
                    r_wr_ptr  <= r_wr_ptr + 1'b1;
                    r_mem_cnt <= r_mem_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Total occupancy moves only on external handshakes; internal fetches just
    // shift a word from RAM to the output stage.
    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + 1'b1;
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
        end else begin
            r_level <= w_level_nxt;
        end
    end

    assign level = r_level;

`ifdef SYNC_RAM_FIFO_AFULL_EN
    localparam logic [LW-1:0] AFULL_LVL = LW'(AFULL_THRESH);

    logic r_almost_full;

    // Computed from next-state level so it lines up with the level register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= (w_level_nxt >= AFULL_LVL);
        end
    end

    assign almost_full = r_almost_full;
`else
    assign almost_full = 1'b0;
`endif

    sync_ram_fifo_out_stage #(
        .DWIDTH (DWIDTH)
    ) u_out_stage (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_fetch     (w_fetch),
        .i_out_ready (out_ready),
        .i_ram_q     (ram_q),
        .o_out_valid (out_valid),
        .o_out_data  (out_data)
    );

endmodule

// File: tb/tb_sync_ram_fifo_ctrl.sv
// Scoreboard bench for sync_ram_fifo_ctrl with a behavioural SYNC_RAM model.
module tb_sync_ram_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;
    localparam int AFT   = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [AW:0]   level;
    logic          almost_full;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic          ram_en;
    logic [DW-1:0] ram_d;
    logic [DW-1:0] ram_q;

    always #5 clk = ~clk;

    sync_ram_fifo_ctrl #(
        .DWIDTH       (DW),
        .AWIDTH       (AW),
        .AFULL_THRESH (AFT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .level       (level),
        .almost_full (almost_full),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_en      (ram_en),
        .ram_d       (ram_d),
        .ram_q       (ram_q)
    );

    // Single-port synchronous RAM: registered read, read-old-on-write.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_d;
            ram_q <= mem[ram_addr];
        end
    end

    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] exp_q[$];
    int            model_level = 0;
    int            wr_cnt = 0;
    int            fetch_cnt = 0;
    logic          m_push;
    logic          m_pop;
    logic [DW-1:0] m_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic afull_exp(input int lvl);
`ifdef SYNC_RAM_FIFO_AFULL_EN
        return lvl >= AFT;
`else
        return 1'b0;
`endif
    endfunction

    // Stimulus side: every accepted write becomes an expected output word.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && in_valid && in_ready) exp_q.push_back(in_data);
        end
    end

    // Monitor: pops the scoreboard on each output handshake and checks the
    // occupancy count and RAM-port usage against handshake-derived counts.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                model_level = 0;
                wr_cnt      = 0;
                fetch_cnt   = 0;
                check("reset_level", 32'(level), 0);
                continue;
            end
            check("level", 32'(level), model_level);
            check("almost_full", 32'(almost_full), 32'(afull_exp(model_level)));
            m_push = in_valid && in_ready;
            m_pop  = out_valid && out_ready;
            if (ram_en && ram_we) begin
                check("wr_addr", 32'(ram_addr), wr_cnt % DEPTH);
                check("wr_data", 32'(ram_d), 32'(in_data));
                check("wr_is_push", 32'(m_push), 1);
                wr_cnt++;
            end
            if (ram_en && !ram_we) begin
                check("fetch_addr", 32'(ram_addr), fetch_cnt % DEPTH);
                check("fetch_stalls_write", 32'(in_ready), 0);
                fetch_cnt++;
            end
            if (m_push) check("push_within_capacity", 32'(model_level <= DEPTH), 1);
            if (m_pop) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL pop_underflow: got 0x%0h, expected no word at %0t", out_data, $time);
                end else begin
                    m_exp = exp_q.pop_front();
                    check("pop_data", 32'(out_data), 32'(m_exp));
                end
            end
            model_level = model_level + int'(m_push) - int'(m_pop);
        end
    end

    int accepted;
    int got;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_level", 32'(level), 0);
        check("rst_almost_full", 32'(almost_full), 0);
        check("rst_ram_en", 32'(ram_en), 0);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_ram_d", 32'(ram_d), 0);

        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("release_in_ready", 32'(in_ready), 1);
        check("release_ram_en", 32'(ram_en), 0);

        // Single word: write at T, fetch at T+1, visible at T+2.
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        out_ready = 1'b1;
        #1;
        check("t0_write_en", 32'(ram_en && ram_we), 1);
        check("t0_write_addr", 32'(ram_addr), 0);
        check("t0_write_d", 32'(ram_d), 8'hA5);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("t1_fetch", 32'(ram_en && !ram_we), 1);
        check("t1_fetch_addr", 32'(ram_addr), 0);
        check("t1_out_valid", 32'(out_valid), 0);
        @(negedge clk);
        #1;
        check("t2_out_valid", 32'(out_valid), 1);
        check("t2_out_data", 32'(out_data), 8'hA5);
        @(negedge clk);
        #1;
        check("t3_out_valid", 32'(out_valid), 0);
        check("t3_level", 32'(level), 0);

        // Fill with the sink stalled: DEPTH RAM words plus one held word.
        out_ready = 1'b0;
        accepted  = 0;
        for (int c = 0; c < 40 && accepted < DEPTH + 1; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'(8'h10 + accepted);
            #1;
            if (in_ready) accepted++;
        end
        check("fill_count", accepted, DEPTH + 1);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        #1;
        check("full_in_ready", 32'(in_ready), 0);
        check("full_level", 32'(level), DEPTH + 1);
        check("full_head", 32'(out_data), 8'h10);
        check("full_almost_full", 32'(almost_full), 32'(afull_exp(DEPTH + 1)));

        // Drain back-to-back across the read-pointer wrap.
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            #1;
            check("drain_valid", 32'(out_valid), 1);
            check("drain_data", 32'(out_data), 32'(8'h10 + i));
            @(negedge clk);
        end
        #1;
        check("drain_empty", 32'(out_valid), 0);

        // Random traffic in three load mixes.
        for (int c = 0; c < 9000; c++) begin
            @(negedge clk);
            case (c / 3000)
                0:       begin in_valid = ($urandom_range(0, 3) != 0); out_ready = ($urandom_range(0, 3) == 0); end
                1:       begin in_valid = ($urandom_range(0, 3) == 0); out_ready = ($urandom_range(0, 3) != 0); end
                default: begin in_valid = $urandom_range(0, 1) == 1;   out_ready = $urandom_range(0, 1) == 1;   end
            endcase
            in_data = 8'($urandom);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 60 && (exp_q.size() != 0 || out_valid); c++) @(negedge clk);
        @(negedge clk);
        #1;
        check("random_drained", exp_q.size(), 0);
        check("random_level_zero", 32'(level), 0);

        // Reset with five words in RAM and a fetch in flight.
        out_ready = 1'b0;
        accepted  = 0;
        for (int c = 0; c < 40 && accepted < 6; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'(8'h60 + accepted);
            #1;
            if (in_ready) accepted++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("pre_reset_hold", 32'(out_data), 8'h60);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("pre_reset_inflight", 32'(out_valid), 1);
        check("pre_reset_inflight_data", 32'(out_data), 8'h61);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_out_valid", 32'(out_valid), 0);
        check("async_rst_level", 32'(level), 0);
        check("async_rst_in_ready", 32'(in_ready), 0);
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        out_ready = 1'b1;
        #1;
        check("post_reset_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (out_valid) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        check("post_reset_valid", got, 1);
        check("post_reset_first_word", 32'(out_data), 8'h3C);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
